// File: rtl/ram_arbiter.sv
// Clears a 32x8 synchronous single-port RAM after reset, then shares it between
// two req/ack requesters with round-robin arbitration and a fixed 4-cycle transaction.
module ram_arbiter #(
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              CLOCK_50,
  input  logic              KEY0,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              init_done,
  output logic              busy
);

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // One extra counter bit so the sweep ends after address 2**ADDR_W-1 has been written.
  localparam logic [ADDR_W:0] CLR_END = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]      state;
  logic [ADDR_W:0] clr_cnt;
  logic            last_grant;
  logic            grant;
  logic            cur_we;
  logic            pick1;

  // Port 1 wins when it is alone, or on a tie when port 0 was served last.
  assign pick1 = req1 & (~req0 | ~last_grant);
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state      <= ST_INIT;
      clr_cnt    <= '0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      cur_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_wren   <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      init_done  <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (clr_cnt == CLR_END) begin
            ram_wren  <= 1'b0;
            init_done <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            ram_addr <= clr_cnt[ADDR_W-1:0];
            ram_data <= INIT_VALUE;
            ram_wren <= 1'b1;
            clr_cnt  <= clr_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (req0 | req1) begin
            grant      <= pick1;
            last_grant <= pick1;
            ram_addr   <= pick1 ? addr1 : addr0;
            ram_data   <= pick1 ? wdata1 : wdata0;
            ram_wren   <= pick1 ? we1 : we0;
            cur_we     <= pick1 ? we1 : we0;
            state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          ram_wren <= 1'b0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // ram_q reflects the address registered at the end of ACCESS.
          if (grant) begin
            if (!cur_we) rdata1 <= ram_q;
            ack1 <= 1'b1;
          end else begin
            if (!cur_we) rdata0 <= ram_q;
            ack0 <= 1'b1;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 32x8 synchronous RAM model
// (registered address, new data visible on read-during-write).
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       KEY0 = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [4:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, ram_wren, init_done, busy;
  logic [7:0] rdata0, rdata1, ram_data, ram_q;
  logic [4:0] ram_addr;

  int total = 0;
  int bad = 0;
  int overlap = 0;

  always #10 clk = ~clk;

  ram_arbiter dut (
    .CLOCK_50(clk), .KEY0(KEY0),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .init_done(init_done), .busy(busy)
  );

  // RAM model, pre-filled with FF so the clear sweep is observable.
  logic [7:0] mem [32];
  logic [4:0] addr_q = '0;
  logic       seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'hFF;
      seeded <= 1'b1;
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_data;
    end
    addr_q <= ram_addr;
  end
  assign ram_q = mem[addr_q];

  always @(negedge clk) if (ack0 && ack1) overlap++;

  task automatic set_req(input int p, input logic we, input logic [4:0] a, input logic [7:0] d);
    if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  task automatic clr_req(input int p);
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  // Waits up to limit edges; edges = -1 when no ack arrived.
  task automatic wait_ack(input int p, input int limit, output int edges);
    edges = -1;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk); #1;
      if ((p == 0) ? ack0 : ack1) begin edges = n; return; end
    end
  endtask

  task automatic idle_sync();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_reset(output int acks, output int wr);
    @(negedge clk); KEY0 = 1'b0;
    @(negedge clk); KEY0 = 1'b1;
    acks = 0; wr = 0;
    repeat (33) begin
      @(posedge clk); #1;
      if (ack0 || ack1) acks++;
      if (ram_wren) wr++;
    end
  endtask

  task automatic test_reset();
    int e;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({ram_addr, ram_data, ram_wren, ack0, ack1} !== 16'h0) begin
      bad++; $display("[TB] FAIL reset_ram: got %h required 0", {ram_addr, ram_data, ram_wren, ack0, ack1}); end
    total++; if ({rdata0, rdata1} !== 16'h0) begin
      bad++; $display("[TB] FAIL reset_rdata: got %h required 0", {rdata0, rdata1}); end
    total++; if ({init_done, busy} !== 2'b01) begin
      bad++; $display("[TB] FAIL reset_flags: got %b required 01", {init_done, busy}); end
    @(negedge clk); KEY0 = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      total++; if ({ram_wren, ram_addr, ram_data} !== {1'b1, 5'(k - 1), 8'h00}) begin
        bad++; $display("[TB] FAIL clear_edge%0d: got %h required %h", k,
                        {ram_wren, ram_addr, ram_data}, {1'b1, 5'(k - 1), 8'h00}); end
      total++; if ({init_done, busy} !== 2'b01) begin
        bad++; $display("[TB] FAIL clear_flags%0d: got %b required 01", k, {init_done, busy}); end
    end
    @(posedge clk); #1;
    total++; if ({init_done, busy, ram_wren} !== 3'b100) begin
      bad++; $display("[TB] FAIL init_done_edge33: got %b required 100", {init_done, busy, ram_wren}); end
    for (int a = 0; a < 32; a++) begin
      idle_sync();
      set_req(0, 1'b0, 5'(a), 8'h00);
      wait_ack(0, 6, e);
      clr_req(0);
      total++; if (e !== 3 || rdata0 !== 8'h00) begin
        bad++; $display("[TB] FAIL readall_%0d: got edges=%0d data=%h required 3/00", a, e, rdata0); end
    end
  endtask

  task automatic test_port0_write_read();
    int e;
    idle_sync();
    set_req(0, 1'b1, 5'd7, 8'hA5);
    @(posedge clk); #1;
    total++; if ({ram_wren, ram_addr, ram_data} !== {1'b1, 5'd7, 8'hA5}) begin
      bad++; $display("[TB] FAIL wr7_ram: got %h required %h", {ram_wren, ram_addr, ram_data}, {1'b1, 5'd7, 8'hA5}); end
    total++; if (busy !== 1'b1) begin
      bad++; $display("[TB] FAIL wr7_busy: got %b required 1", busy); end
    wait_ack(0, 4, e);
    clr_req(0);
    total++; if (e !== 2) begin
      bad++; $display("[TB] FAIL wr7_latency: got %0d required 2", e); end
    idle_sync();
    set_req(0, 1'b0, 5'd7, 8'h00);
    @(posedge clk); #1;
    total++; if (ram_wren !== 1'b0) begin
      bad++; $display("[TB] FAIL rd7_wren: got %b required 0", ram_wren); end
    wait_ack(0, 4, e);
    clr_req(0);
    total++; if (e !== 2) begin
      bad++; $display("[TB] FAIL rd7_latency: got %0d required 2", e); end
    total++; if ({rdata0, rdata1} !== {8'hA5, 8'h00}) begin
      bad++; $display("[TB] FAIL rd7_data: got %h required a500", {rdata0, rdata1}); end
  endtask

  task automatic test_tie();
    int e, acks, wr;
    do_reset(acks, wr);
    idle_sync();
    set_req(0, 1'b1, 5'd1, 8'h3C);
    set_req(1, 1'b0, 5'd1, 8'h00);
    wait_ack(0, 5, e);
    clr_req(0);
    total++; if (e !== 3 || ack1 !== 1'b0) begin
      bad++; $display("[TB] FAIL tie1_first: got edges=%0d ack1=%b required 3/0", e, ack1); end
    wait_ack(1, 6, e);
    clr_req(1);
    total++; if (e !== 4 || rdata1 !== 8'h3C) begin
      bad++; $display("[TB] FAIL tie1_second: got edges=%0d rdata1=%h required 4/3c", e, rdata1); end
    idle_sync();
    set_req(0, 1'b0, 5'd1, 8'h00);
    set_req(1, 1'b1, 5'd2, 8'h55);
    wait_ack(0, 5, e);
    clr_req(0);
    total++; if (e !== 3 || rdata0 !== 8'h3C) begin
      bad++; $display("[TB] FAIL tie2_first: got edges=%0d rdata0=%h required 3/3c", e, rdata0); end
    wait_ack(1, 6, e);
    clr_req(1);
    total++; if (e !== 4) begin
      bad++; $display("[TB] FAIL tie2_second: got %0d required 4", e); end
  endtask

  task automatic test_back_to_back();
    int ports[8];
    int edges[8];
    int n = 0;
    idle_sync();
    set_req(0, 1'b0, 5'd1, 8'h00);
    set_req(1, 1'b0, 5'd2, 8'h00);
    for (int k = 1; k <= 40 && n < 8; k++) begin
      @(posedge clk); #1;
      if (ack0 || ack1) begin
        ports[n] = ack1 ? 1 : 0;
        edges[n] = k;
        n++;
      end
    end
    clr_req(0); clr_req(1);
    total++; if (n !== 8) begin
      bad++; $display("[TB] FAIL b2b_count: got %0d required 8", n); end
    total++; if (n > 0 && edges[0] !== 3) begin
      bad++; $display("[TB] FAIL b2b_first_edge: got %0d required 3", edges[0]); end
    for (int i = 0; i < n; i++) begin
      total++; if (ports[i] !== (i % 2)) begin
        bad++; $display("[TB] FAIL b2b_order%0d: got port %0d required %0d", i, ports[i], i % 2); end
      if (i > 0) begin
        total++; if (edges[i] - edges[i-1] !== 4) begin
          bad++; $display("[TB] FAIL b2b_gap%0d: got %0d required 4", i, edges[i] - edges[i-1]); end
      end
    end
    total++; if ({rdata0, rdata1} !== {8'h3C, 8'h55}) begin
      bad++; $display("[TB] FAIL b2b_data: got %h required 3c55", {rdata0, rdata1}); end
  endtask

  task automatic test_req_during_init();
    int e;
    int early = 0;
    @(negedge clk); KEY0 = 1'b0;
    set_req(0, 1'b1, 5'd3, 8'h99);
    @(negedge clk); KEY0 = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk); #1;
      if (ack0 || ram_data !== 8'h00) early++;
    end
    total++; if (early !== 0 || init_done !== 1'b1) begin
      bad++; $display("[TB] FAIL init_req_blocked: got early=%0d init_done=%b required 0/1", early, init_done); end
    @(posedge clk); #1;
    total++; if ({ram_wren, ram_addr, ram_data} !== {1'b1, 5'd3, 8'h99}) begin
      bad++; $display("[TB] FAIL init_req_grant: got %h required %h", {ram_wren, ram_addr, ram_data}, {1'b1, 5'd3, 8'h99}); end
    wait_ack(0, 4, e);
    clr_req(0);
    total++; if (e !== 2) begin
      bad++; $display("[TB] FAIL init_req_latency: got %0d required 2", e); end
  endtask

  task automatic test_abort();
    int e, acks, wr;
    idle_sync();
    set_req(0, 1'b1, 5'd9, 8'h77);
    wait_ack(0, 5, e);
    clr_req(0);
    idle_sync();
    set_req(0, 1'b1, 5'd9, 8'hEE);
    @(posedge clk); #4;
    KEY0 = 1'b0;
    #1;
    total++; if ({ram_addr, ram_data, ram_wren, ack0, ack1, rdata0, rdata1} !== 32'h0) begin
      bad++; $display("[TB] FAIL abort_outputs: got %h required 0",
                      {ram_addr, ram_data, ram_wren, ack0, ack1, rdata0, rdata1}); end
    total++; if ({init_done, busy} !== 2'b01) begin
      bad++; $display("[TB] FAIL abort_flags: got %b required 01", {init_done, busy}); end
    clr_req(0);
    do_reset(acks, wr);
    total++; if (acks !== 0 || wr !== 32) begin
      bad++; $display("[TB] FAIL abort_sweep: got acks=%0d wren=%0d required 0/32", acks, wr); end
    idle_sync();
    set_req(0, 1'b0, 5'd9, 8'h00);
    wait_ack(0, 6, e);
    clr_req(0);
    total++; if (e !== 3 || rdata0 !== 8'h00) begin
      bad++; $display("[TB] FAIL abort_cleared: got edges=%0d data=%h required 3/00", e, rdata0); end
  endtask

  initial begin
    test_reset();
    test_port0_write_read();
    test_tie();
    test_back_to_back();
    test_req_during_init();
    test_abort();
    total++; if (overlap !== 0) begin
      bad++; $display("[TB] FAIL ack_overlap: got %0d required 0", overlap); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
